// File: rtl/periph_out_uart_streamer.sv
// Streams changes of the hart's output peripheral bytes as UART frames {SYNC_BYTE, index, value}.
// Optional even-parity bit per byte when PERIPH_STREAM_PARITY_EN is defined.
module periph_out_uart_streamer #(
    parameter int         OUTPUT_PERIPH_LEN = 'h20,
    parameter int         CLKS_PER_BIT      = 434,
    parameter logic [7:0] SYNC_BYTE         = 8'hA5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  output_peripherals_mem [OUTPUT_PERIPH_LEN],
    output logic        tx,
    output logic        busy,
    output logic [15:0] frames_sent
);
    localparam int IDX_W = (OUTPUT_PERIPH_LEN > 1) ? $clog2(OUTPUT_PERIPH_LEN) : 1;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {SCAN, START, DATA, PARITY, STOP} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx, idx_next;
    logic [7:0]         shadow [OUTPUT_PERIPH_LEN];
    logic [CNT_W-1:0]   clk_cnt;
    logic [2:0]         bit_cnt;
    logic [1:0]         byte_sel;
    logic [7:0]         frame_idx, frame_val, cur_byte;
    logic               clk_last, changed;

    assign changed  = output_peripherals_mem[idx] != shadow[idx];
    assign idx_next = (idx == IDX_W'(OUTPUT_PERIPH_LEN - 1)) ? '0 : idx + 1'b1;
    assign clk_last = clk_cnt == CNT_W'(CLKS_PER_BIT - 1);

    always_comb begin
        case (byte_sel)
            2'd0:    cur_byte = SYNC_BYTE;
            2'd1:    cur_byte = frame_idx;
            default: cur_byte = frame_val;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) state <= SCAN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SCAN:  if (changed) state_nxt = START;
            START: if (clk_last) state_nxt = DATA;
            DATA:
                if (clk_last && bit_cnt == 3'd7)
`ifdef PERIPH_STREAM_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
`ifdef PERIPH_STREAM_PARITY_EN
            PARITY: if (clk_last) state_nxt = STOP;
`endif
            STOP:  if (clk_last) state_nxt = (byte_sel == 2'd2) ? SCAN : START;
            default: state_nxt = SCAN;
        endcase
    end

    always_comb begin
        tx   = 1'b1;
        busy = state != SCAN;
        case (state)
            START: tx = 1'b0;
            DATA:  tx = cur_byte[bit_cnt];
`ifdef PERIPH_STREAM_PARITY_EN
            PARITY: tx = ^cur_byte;
`endif
            default: tx = 1'b1;
        endcase
    end

    // Scan pointer is held during a frame and steps past the sent byte once it completes.
    always_ff @(posedge clock) begin
        if (!reset) begin
            idx         <= '0;
            clk_cnt     <= '0;
            bit_cnt     <= '0;
            byte_sel    <= '0;
            frames_sent <= '0;
            for (int i = 0; i < OUTPUT_PERIPH_LEN; i++) shadow[i] <= '0;
        end else begin
            case (state)
                SCAN: begin
                    clk_cnt <= '0;
                    bit_cnt <= '0;
                    if (changed) begin
                        frame_idx   <= 8'(idx);
                        frame_val   <= output_peripherals_mem[idx];
                        shadow[idx] <= output_peripherals_mem[idx];
                        byte_sel    <= '0;
                    end else begin
                        idx <= idx_next;
                    end
                end
                default: begin
                    clk_cnt <= clk_last ? '0 : clk_cnt + 1'b1;
                    if (state == DATA && clk_last) bit_cnt <= bit_cnt + 1'b1;
                    if (state == STOP && clk_last) begin
                        if (byte_sel == 2'd2) begin
                            frames_sent <= frames_sent + 1'b1;
                            idx         <= idx_next;
                        end else begin
                            byte_sel <= byte_sel + 1'b1;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_periph_out_uart_streamer.sv
// Bench for periph_out_uart_streamer: UART receiver model decodes tx, frames checked against a scoreboard queue.
module tb_periph_out_uart_streamer;
    localparam int LEN = 32;
    localparam int CPB = 4;
`ifdef PERIPH_STREAM_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME_CYC = 3 * NB * CPB;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  mem [LEN];
    logic        tx, busy;
    logic [15:0] frames_sent;

    always #5 clock = ~clock;

    periph_out_uart_streamer #(
        .OUTPUT_PERIPH_LEN(LEN),
        .CLKS_PER_BIT(CPB),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .clock(clock),
        .reset(reset),
        .output_peripherals_mem(mem),
        .tx(tx),
        .busy(busy),
        .frames_sent(frames_sent)
    );

    typedef struct {
        logic [7:0] addr;
        logic [7:0] val;
        bit         exp_frame;
    } vec_t;

    vec_t        vecs [7];
    logic [15:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;

    bit          rx_active = 0;
    int          rx_t = 0;
    logic [7:0]  rx_shift = '0;
    logic [7:0]  rx_bytes [3];
    int          rx_nbytes = 0;
    int          frames_rx = 0;
    bit          prev_busy = 0;
    int          busy_run = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic byte_done();
        logic [15:0] e;
        rx_bytes[rx_nbytes] = rx_shift;
        rx_nbytes++;
        if (rx_nbytes == 3) begin
            rx_nbytes = 0;
            frames_rx++;
            chk("sync_byte", 32'(rx_bytes[0]), 32'h A5);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame actual=%0h_%0h required=none", rx_bytes[1], rx_bytes[2]);
            end else begin
                e = exp_q.pop_front();
                chk("frame_idx", 32'(rx_bytes[1]), 32'(e[15:8]));
                chk("frame_val", 32'(rx_bytes[2]), 32'(e[7:0]));
            end
        end
    endtask

    // One receiver/busy-monitor step per falling edge.
    task automatic rx_step();
        int k;
        if (!reset) begin
            rx_active = 0;
            rx_nbytes = 0;
            prev_busy = 0;
            busy_run  = 0;
            return;
        end
        if (busy && !prev_busy) chk("start_with_busy", 32'(tx), 32'd0);
        if (busy) busy_run++;
        else if (prev_busy) begin
            chk("busy_cycles", 32'(busy_run), 32'(FRAME_CYC));
            busy_run = 0;
        end
        prev_busy = busy;
        if (!rx_active && !tx) begin
            rx_active = 1;
            rx_t = 0;
        end
        if (rx_active) begin
            if (rx_t % CPB == CPB / 2) begin
                k = rx_t / CPB;
                if (k == 0) chk("start_bit", 32'(tx), 32'd0);
                else if (k <= 8) rx_shift[k-1] = tx;
                else if (k == NB - 1) begin
                    chk("stop_bit", 32'(tx), 32'd1);
                    rx_active = 0;
                    byte_done();
                end else chk("parity_bit", 32'(tx), 32'(^rx_shift));
            end
            rx_t++;
        end
    endtask

    task automatic tick();
        @(negedge clock);
        rx_step();
    endtask

    task automatic wait_quiet(input int budget);
        int n = 0;
        repeat (LEN + 4) tick();
        while ((exp_q.size() != 0 || rx_active || rx_nbytes != 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        chk("quiet_within_budget", 32'(n < budget), 32'd1);
    endtask

    task automatic wait_busy();
        int n = 0;
        while (!busy && n < 100) begin
            tick();
            n++;
        end
        chk("busy_rise", 32'(busy), 32'd1);
    endtask

    initial begin
        bit bad;
        int expected;
        vecs[0] = '{8'h00, 8'h80, 1'b1};
        vecs[1] = '{8'h1F, 8'h55, 1'b1};
        vecs[2] = '{8'h10, 8'h00, 1'b0};
        vecs[3] = '{8'h05, 8'h3C, 1'b0};
        vecs[4] = '{8'h01, 8'hAA, 1'b1};
        vecs[5] = '{8'h03, 8'h07, 1'b1};
        vecs[6] = '{8'h1E, 8'hFF, 1'b1};
        foreach (mem[i]) mem[i] = 8'h00;

        // Reset and long idle
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        bad = 0;
        repeat (500) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0) bad = 1;
        end
        chk("reset_idle", 32'(bad), 32'd0);
        chk("reset_frames_sent", 32'(frames_sent), 32'd0);

        // Single change
        mem[5] = 8'h3C;
        exp_q.push_back({8'h05, 8'h3C});
        wait_quiet(400);
        chk("single_frames_sent", 32'(frames_sent), 32'd1);
        repeat (200) tick();
        chk("single_no_extra", 32'(frames_sent), 32'd1);
        chk("single_rx_count", 32'(frames_rx), 32'd1);

        // Simultaneous changes right out of reset (idx=0)
        reset = 1'b0;
        foreach (mem[i]) mem[i] = 8'h00;
        repeat (2) tick();
        mem[2]    = 8'hFF;
        mem[5'h1F] = 8'h01;
        reset = 1'b1;
        exp_q.push_back({8'h02, 8'hFF});
        exp_q.push_back({8'h1F, 8'h01});
        wait_quiet(800);
        chk("simul_frames_sent", 32'(frames_sent), 32'd2);

        // Change while busy: intermediate value lost
        mem[5] = 8'h11;
        exp_q.push_back({8'h05, 8'h11});
        wait_busy();
        repeat (10) tick();
        mem[5] = 8'h22;
        repeat (20) tick();
        mem[5] = 8'h33;
        exp_q.push_back({8'h05, 8'h33});
        wait_quiet(800);
        chk("busy_change_frames_sent", 32'(frames_sent), 32'd4);

        // Reset during the index byte's data bits
        mem[5] = 8'h3C;
        exp_q.push_back({8'h05, 8'h3C});
        wait_busy();
        repeat (13 * CPB) tick();
        reset = 1'b0;
        tick();
        chk("midreset_tx", 32'(tx), 32'd1);
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_frames_sent", 32'(frames_sent), 32'd0);
        exp_q.delete();
        mem[2]     = 8'h00;
        mem[5'h1F] = 8'h00;
        tick();
        reset = 1'b1;
        exp_q.push_back({8'h05, 8'h3C});
        wait_quiet(400);
        chk("resend_frames_sent", 32'(frames_sent), 32'd1);

        // Table of single writes, some of which must not produce a frame
        expected = 1;
        for (int i = 0; i < 7; i++) begin
            mem[vecs[i].addr[4:0]] = vecs[i].val;
            if (vecs[i].exp_frame) begin
                exp_q.push_back({vecs[i].addr, vecs[i].val});
                expected++;
            end
            wait_quiet(400);
            chk("vec_frames_sent", 32'(frames_sent), 32'(expected));
        end
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
